ahb_resp_mux: RTL and testbench
===============================

AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 Parameter NUM_SLV, default 16, SHALL set the number of slave ports (legal range 1..16).
REQ-002 Parameter DW, default 32, SHALL set the read-data width (32 or 64).
REQ-003 Parameter SEL_LSB, default 28, SHALL set the LSB of the 4-bit slot field HADDR_i[SEL_LSB+3:SEL_LSB].
REQ-004 HCLK  input  1  bus clock; the single clock, all state on rising edge.
REQ-005 HRST  input  1  synchronous active-high reset.
REQ-006 HADDR_i  input  32  address-phase address from master.
REQ-007 HTRANS_i  input  2  address-phase transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
REQ-008 HSEL_o  output  NUM_SLV  combinational one-hot slave select from current address phase.
REQ-009 HREADY_i  input  NUM_SLV  per-slave HREADYOUT.
REQ-010 HRDATA_i  input  NUM_SLV x DW  per-slave read data (unpacked array).
REQ-011 HRESP_i  input  NUM_SLV  per-slave response (0 OKAY, 1 ERROR).
REQ-012 HRDATA_o, HREADY_o, HRESP_o  output  DW/1/1  muxed data-phase response to master and slaves' HREADY.
REQ-013 TIMEOUT_o  output  1  one-cycle pulse on watchdog expiry (present only per REQ-034).

Function
REQ-014 Slot = HADDR_i[SEL_LSB+3:SEL_LSB]; slot < NUM_SLV SHALL be mapped, slot >= NUM_SLV unmapped.
REQ-015 HSEL_o[slot] SHALL be 1 for a mapped slot regardless of HTRANS_i; all zero for unmapped.
REQ-016 Address phase SHALL be accepted only on cycles where HREADY_o = 1; the data-phase state SHALL update then and only then.
REQ-017 FSM states: IDLE (no active data phase), SLV (data phase owned by registered slot k), ERR1, ERR2.
REQ-018 On acceptance: HTRANS_i IDLE/BUSY -> IDLE; NONSEQ/SEQ to mapped slot -> SLV with k latched; NONSEQ/SEQ to unmapped slot -> ERR1.
REQ-019 IDLE: HREADY_o = 1, HRESP_o = 0, HRDATA_o = 0 (zero-wait OKAY).
REQ-020 SLV: HRDATA_o/HREADY_o/HRESP_o SHALL equal HRDATA_i[k]/HREADY_i[k]/HRESP_i[k] combinationally; no added latency.
REQ-021 SLV with HREADY_i[k] = 0 SHALL hold k unchanged; new address is not accepted.
REQ-022 ERR1: HREADY_o = 0, HRESP_o = 1, HRDATA_o = 0; SHALL go to ERR2 next cycle unconditionally.
REQ-023 ERR2: HREADY_o = 1, HRESP_o = 1, HRDATA_o = 0; next state per REQ-018 from the address phase present in ERR2.
REQ-024 Back-to-back transfers SHALL pipeline: the cycle completing a data phase accepts the next address phase, with no bubble.
REQ-025 A slave's two-cycle ERROR (HREADY_i=0,HRESP_i=1 then 1,1) SHALL pass through unchanged in SLV.
REQ-026 No output SHALL be X or floating for any state/slot combination, including NUM_SLV < 16.

Reset
REQ-027 HRST sampled high SHALL force state IDLE and k = 0 on the next HCLK edge, overriding any in-flight transfer or wait state.
REQ-028 During and after reset, until the first accepted transfer, outputs SHALL be HREADY_o = 1, HRESP_o = 0, HRDATA_o = 0, TIMEOUT_o = 0.
REQ-029 A transfer presented in the cycle HRST is high SHALL be discarded.

Configuration
REQ-030 Macro AHB_RESP_MUX_TIMEOUT_EN SHALL enable a data-phase watchdog; parameter TO_CYCLES, default 256, SHALL exist only when the macro is defined.
REQ-031 With the macro: a counter SHALL clear on entry to SLV and increment each SLV cycle with HREADY_i[k] = 0.
REQ-032 When the count reaches TO_CYCLES, the next cycle SHALL enter ERR1 (slave outputs ignored), TIMEOUT_o SHALL pulse 1 for that one cycle, and the normal ERR1->ERR2 sequence SHALL follow.
REQ-033 Counter SHALL saturate, never wrap, and clear on reset.
REQ-034 Without the macro: no counter, no TO_CYCLES, no TIMEOUT_o port; SLV waits indefinitely.

Verification
REQ-035 Reset: assert HRST 2 cycles mid wait state on slave 3 -> state IDLE, HREADY_o=1, HRESP_o=0, HRDATA_o=0.
REQ-036 Pipelined reads: NONSEQ 0x1000_0000 then SEQ 0x2000_0000, slaves 1/2 zero-wait returning 0xA5A5_0001/0xA5A5_0002 -> HRDATA_o shows each on consecutive cycles, HSEL_o = 0x0002 then 0x0004.
REQ-037 Wait state: slave 5 holds HREADY_i[5]=0 for 3 cycles while HADDR_i changes to slave 6 -> HREADY_o=0 for 3 cycles, output stays on slave 5, slave 6 data phase starts after.
REQ-038 Unmapped: NUM_SLV=8, NONSEQ 0x9000_0000 -> cycle1 HREADY_o=0,HRESP_o=1; cycle2 HREADY_o=1,HRESP_o=1; IDLE 0x9000_0000 -> zero-wait OKAY.
REQ-039 Timeout (macro on, TO_CYCLES=4): slave 0 stuck HREADY_i[0]=0 -> after 4 wait cycles TIMEOUT_o pulses once, then two-cycle ERROR; macro off -> HREADY_o stays 0.

Source files
------------

// File: rtl/ahb_resp_mux.sv
// AHB data-phase response multiplexer: decodes a 4-bit slot from HADDR_i and routes the owning slave's response back to the master.
// Optional data-phase watchdog is enabled by defining AHB_RESP_MUX_TIMEOUT_EN (adds TO_CYCLES and TIMEOUT_o).
module ahb_resp_mux #(
  parameter int NUM_SLV = 16,
  parameter int DW      = 32,
  parameter int SEL_LSB = 28
`ifdef AHB_RESP_MUX_TIMEOUT_EN
  ,
  parameter int TO_CYCLES = 256
`endif
) (
  input  logic               HCLK,
  input  logic               HRST,
  input  logic [31:0]        HADDR_i,
  input  logic [1:0]         HTRANS_i,
  output logic [NUM_SLV-1:0] HSEL_o,
  input  logic [NUM_SLV-1:0] HREADY_i,
  input  logic [DW-1:0]      HRDATA_i [NUM_SLV],
  input  logic [NUM_SLV-1:0] HRESP_i,
  output logic [DW-1:0]      HRDATA_o,
  output logic               HREADY_o,
  output logic               HRESP_o
`ifdef AHB_RESP_MUX_TIMEOUT_EN
  ,
  output logic               TIMEOUT_o
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_SLV, ST_ERR1, ST_ERR2} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_slot;
  logic [3:0]    w_slot_next;
  logic [3:0]    w_slot;
  logic          w_mapped;
  logic          w_req;
  logic          w_accept;
  logic          w_ready;
  logic          w_resp;
  logic [DW-1:0] w_rdata;
  logic          w_ready_k;
  logic          w_resp_k;
  logic [DW-1:0] w_rdata_k;
  logic          w_unused_addr;

  assign w_slot        = HADDR_i[SEL_LSB+3:SEL_LSB];
  assign w_mapped      = ({1'b0, w_slot} < 5'(NUM_SLV));
  assign w_req         = HTRANS_i[1];
  assign w_unused_addr = ^HADDR_i;

  generate
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
      assign HSEL_o[gi] = (w_slot == 4'(gi));
    end
  endgenerate

  // Compare-select mux keeps the output defined even if r_slot ever points past NUM_SLV.
  always_comb begin
    w_ready_k = 1'b0;
    w_resp_k  = 1'b0;
    w_rdata_k = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_slot == 4'(i)) begin
        w_ready_k = HREADY_i[i];
        w_resp_k  = HRESP_i[i];
        w_rdata_k = HRDATA_i[i];
      end
    end
  end

  assign w_accept = w_ready;

`ifdef AHB_RESP_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_to;
  logic          w_to_next;
  logic          w_expire;

  // Expiry fires on the edge where the wait count reaches TO_CYCLES.
  assign w_expire = (r_state == ST_SLV) && !w_ready_k && (r_cnt == CW'(TO_CYCLES - 1));
`endif

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_slot_next  = r_slot;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
    w_to_next    = 1'b0;
`endif
    if (r_state == ST_ERR1) begin
      w_state_next = ST_ERR2;
    end else if (w_accept) begin
      if (!w_req) begin
        w_state_next = ST_IDLE;
      end else if (w_mapped) begin
        w_state_next = ST_SLV;
        w_slot_next  = w_slot;
      end else begin
        w_state_next = ST_ERR1;
      end
    end
`ifdef AHB_RESP_MUX_TIMEOUT_EN
    else if (w_expire) begin
      w_state_next = ST_ERR1;
      w_to_next    = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_state <= ST_IDLE;
      r_slot  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_slot  <= w_slot_next;
    end
  end

`ifdef AHB_RESP_MUX_TIMEOUT_EN
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      r_to <= w_to_next;
      if (w_accept && (w_state_next == ST_SLV)) begin
        r_cnt <= '0;
      end else if ((r_state == ST_SLV) && !w_ready_k && (r_cnt != CW'(TO_CYCLES))) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`endif

  // Output logic.
  always_comb begin
    w_ready = 1'b1;
    w_resp  = 1'b0;
    w_rdata = '0;
    case (r_state)
      ST_SLV: begin
        w_ready = w_ready_k;
        w_resp  = w_resp_k;
        w_rdata = w_rdata_k;
      end
      ST_ERR1: begin
        w_ready = 1'b0;
        w_resp  = 1'b1;
      end
      ST_ERR2: begin
        w_ready = 1'b1;
        w_resp  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset presents a zero-wait OKAY even in the cycle it is first sampled.
  assign HREADY_o = HRST ? 1'b1 : w_ready;
  assign HRESP_o  = HRST ? 1'b0 : w_resp;
  assign HRDATA_o = HRST ? '0   : w_rdata;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
  assign TIMEOUT_o = r_to & ~HRST;
`endif

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed self-checking bench for ahb_resp_mux (8 slaves; watchdog scenario follows AHB_RESP_MUX_TIMEOUT_EN).
module tb_ahb_resp_mux;

  localparam int NS = 8;

  logic          HCLK;
  logic          HRST;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic [NS-1:0] hsel;
  logic [NS-1:0] hready;
  logic [31:0]   hrdata [NS];
  logic [NS-1:0] hresp;
  logic [31:0]   hrdata_o;
  logic          hready_o;
  logic          hresp_o;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
  logic          timeout_o;
`endif

  int checks = 0;
  int errors = 0;

  ahb_resp_mux #(
    .NUM_SLV(NS),
    .DW(32),
    .SEL_LSB(28)
`ifdef AHB_RESP_MUX_TIMEOUT_EN
    ,
    .TO_CYCLES(4)
`endif
  ) u_dut (
    .HCLK(HCLK),
    .HRST(HRST),
    .HADDR_i(haddr),
    .HTRANS_i(htrans),
    .HSEL_o(hsel),
    .HREADY_i(hready),
    .HRDATA_i(hrdata),
    .HRESP_i(hresp),
    .HRDATA_o(hrdata_o),
    .HREADY_o(hready_o),
    .HRESP_o(hresp_o)
`ifdef AHB_RESP_MUX_TIMEOUT_EN
    ,
    .TIMEOUT_o(timeout_o)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  task automatic show(input string tag);
    $display("t=%0t %-14s haddr=%h htrans=%0d hsel=%h ready=%b resp=%b data=%h",
             $time, tag, haddr, htrans, hsel, hready_o, hresp_o, hrdata_o);
  endtask

  task automatic test_reset;
    HRST = 1'b1; htrans = 2'd0; haddr = 32'h0;
    @(negedge HCLK); show("reset0");
    checks++; if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL rst_idle0: got %b/%b/%h exp 1/0/00000000", hready_o, hresp_o, hrdata_o); end
    step;
    @(negedge HCLK); show("reset1");
    checks++; if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL rst_idle1: got %b/%b/%h exp 1/0/00000000", hready_o, hresp_o, hrdata_o); end
    step;
    HRST = 1'b0; haddr = 32'h3000_0000; htrans = 2'd2;
    @(negedge HCLK); show("nonseq s3");
    checks++; if (hsel !== 8'h08) begin errors++; $display("FAIL rst_hsel3: got %h exp 08", hsel); end
    step;
    htrans = 2'd0; hready[3] = 1'b0;
    @(negedge HCLK); show("s3 wait");
    checks++; if ({hready_o, hrdata_o} !== {1'b0, 32'hD000_0003}) begin errors++; $display("FAIL rst_s3wait: got %b/%h exp 0/d0000003", hready_o, hrdata_o); end
    step;
    HRST = 1'b1; htrans = 2'd2;
    @(negedge HCLK); show("reset mid wait");
    checks++; if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL rst_mid0: got %b/%b/%h exp 1/0/00000000", hready_o, hresp_o, hrdata_o); end
    step;
    @(negedge HCLK); show("reset mid wait");
    checks++; if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL rst_mid1: got %b/%b/%h exp 1/0/00000000", hready_o, hresp_o, hrdata_o); end
    step;
    HRST = 1'b0; htrans = 2'd0;
    @(negedge HCLK); show("after reset");
    checks++; if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL rst_after: got %b/%b/%h exp 1/0/00000000", hready_o, hresp_o, hrdata_o); end
    step;
    hready[3] = 1'b1;
  endtask

  task automatic test_pipeline;
    hrdata[1] = 32'hA5A5_0001; hrdata[2] = 32'hA5A5_0002;
    haddr = 32'h1000_0000; htrans = 2'd2;
    @(negedge HCLK); show("nonseq s1");
    checks++; if ({hsel, hready_o, hrdata_o} !== {8'h02, 1'b1, 32'h0}) begin errors++; $display("FAIL pipe_a: got %h/%b/%h exp 02/1/00000000", hsel, hready_o, hrdata_o); end
    step;
    haddr = 32'h2000_0000; htrans = 2'd3;
    @(negedge HCLK); show("seq s2");
    checks++; if ({hsel, hready_o, hresp_o, hrdata_o} !== {8'h04, 1'b1, 1'b0, 32'hA5A5_0001}) begin errors++; $display("FAIL pipe_b: got %h/%b/%b/%h exp 04/1/0/a5a50001", hsel, hready_o, hresp_o, hrdata_o); end
    step;
    htrans = 2'd0;
    @(negedge HCLK); show("data s2");
    checks++; if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'hA5A5_0002}) begin errors++; $display("FAIL pipe_c: got %b/%b/%h exp 1/0/a5a50002", hready_o, hresp_o, hrdata_o); end
    step;
    @(negedge HCLK); show("idle");
    checks++; if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL pipe_idle: got %b/%b/%h exp 1/0/00000000", hready_o, hresp_o, hrdata_o); end
    step;
  endtask

  task automatic test_wait_state;
    hrdata[5] = 32'h5555_0005; hrdata[6] = 32'h6666_0006;
    haddr = 32'h5000_0000; htrans = 2'd2;
    @(negedge HCLK); show("nonseq s5");
    step;
    haddr = 32'h6000_0000; hready[5] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK); show("s5 wait");
      checks++; if ({hready_o, hrdata_o} !== {1'b0, 32'h5555_0005}) begin errors++; $display("FAIL wait_%0d: got %b/%h exp 0/55550005", c, hready_o, hrdata_o); end
      step;
    end
    hready[5] = 1'b1;
    @(negedge HCLK); show("s5 done");
    checks++; if ({hsel, hready_o, hrdata_o} !== {8'h40, 1'b1, 32'h5555_0005}) begin errors++; $display("FAIL wait_done: got %h/%b/%h exp 40/1/55550005", hsel, hready_o, hrdata_o); end
    step;
    htrans = 2'd0;
    @(negedge HCLK); show("data s6");
    checks++; if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'h6666_0006}) begin errors++; $display("FAIL wait_s6: got %b/%b/%h exp 1/0/66660006", hready_o, hresp_o, hrdata_o); end
    step;
  endtask

  task automatic test_slave_error;
    haddr = 32'h4000_0000; htrans = 2'd2;
    @(negedge HCLK); show("nonseq s4");
    step;
    htrans = 2'd0; hready[4] = 1'b0; hresp[4] = 1'b1;
    @(negedge HCLK); show("s4 err1");
    checks++; if ({hready_o, hresp_o} !== 2'b01) begin errors++; $display("FAIL serr_1: got %b%b exp 01", hready_o, hresp_o); end
    step;
    hready[4] = 1'b1;
    @(negedge HCLK); show("s4 err2");
    checks++; if ({hready_o, hresp_o} !== 2'b11) begin errors++; $display("FAIL serr_2: got %b%b exp 11", hready_o, hresp_o); end
    step;
    hresp[4] = 1'b0;
    @(negedge HCLK); show("idle");
    checks++; if ({hready_o, hresp_o} !== 2'b10) begin errors++; $display("FAIL serr_idle: got %b%b exp 10", hready_o, hresp_o); end
    step;
  endtask

  task automatic test_unmapped;
    haddr = 32'h9000_0000; htrans = 2'd2;
    @(negedge HCLK); show("nonseq unmap");
    checks++; if ({hsel, hready_o} !== {8'h00, 1'b1}) begin errors++; $display("FAIL unm_sel: got %h/%b exp 00/1", hsel, hready_o); end
    step;
    htrans = 2'd0;
    @(negedge HCLK); show("unmap err1");
    checks++; if ({hready_o, hresp_o, hrdata_o} !== {1'b0, 1'b1, 32'h0}) begin errors++; $display("FAIL unm_err1: got %b/%b/%h exp 0/1/00000000", hready_o, hresp_o, hrdata_o); end
    step;
    @(negedge HCLK); show("unmap err2");
    checks++; if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL unm_err2: got %b/%b/%h exp 1/1/00000000", hready_o, hresp_o, hrdata_o); end
    step;
    @(negedge HCLK); show("idle unmap");
    checks++; if ({hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL unm_idle: got %b/%b/%h exp 1/0/00000000", hready_o, hresp_o, hrdata_o); end
    step;
  endtask

  task automatic test_timeout;
    haddr = 32'h0000_0000; htrans = 2'd2;
    @(negedge HCLK); show("nonseq s0");
    step;
    htrans = 2'd0; hready[0] = 1'b0;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      @(negedge HCLK); show("s0 stuck");
      checks++; if ({hready_o, timeout_o} !== 2'b00) begin errors++; $display("FAIL to_wait_%0d: got ready=%b to=%b exp 0/0", c, hready_o, timeout_o); end
      step;
    end
    @(negedge HCLK); show("timeout err1");
    checks++; if ({timeout_o, hready_o, hresp_o, hrdata_o} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin errors++; $display("FAIL to_err1: got to=%b %b/%b/%h exp 1 0/1/00000000", timeout_o, hready_o, hresp_o, hrdata_o); end
    step;
    @(negedge HCLK); show("timeout err2");
    checks++; if ({timeout_o, hready_o, hresp_o} !== {1'b0, 1'b1, 1'b1}) begin errors++; $display("FAIL to_err2: got to=%b %b/%b exp 0 1/1", timeout_o, hready_o, hresp_o); end
    step;
    @(negedge HCLK); show("idle");
    checks++; if ({timeout_o, hready_o, hresp_o} !== {1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL to_idle: got to=%b %b/%b exp 0 1/0", timeout_o, hready_o, hresp_o); end
    step;
    hready[0] = 1'b1;
`else
    for (int c = 0; c < 8; c++) begin
      @(negedge HCLK); show("s0 stuck");
      checks++; if ({hready_o, hresp_o} !== 2'b00) begin errors++; $display("FAIL nto_wait_%0d: got %b%b exp 00", c, hready_o, hresp_o); end
      step;
    end
    hready[0] = 1'b1;
    @(negedge HCLK); show("s0 release");
    checks++; if ({hready_o, hrdata_o} !== {1'b1, 32'hD000_0000}) begin errors++; $display("FAIL nto_release: got %b/%h exp 1/d0000000", hready_o, hrdata_o); end
    step;
`endif
  endtask

  initial begin
    haddr = 32'h0; htrans = 2'd0; HRST = 1'b1;
    hready = '1; hresp = '0;
    for (int i = 0; i < NS; i++) hrdata[i] = 32'hD000_0000 + 32'(i);
    test_reset;
    test_pipeline;
    test_wait_state;
    test_slave_error;
    test_unmapped;
    test_timeout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
